// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter over 2**N requesters presenting a registered binary
// grant index on a valid/ready handshake. Define RR_GRANT_LOCK_EN for burst lock.
module rr_grant_encoder #(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**N-1:0]   req,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [N-1:0]      grant_index
);

  localparam int unsigned NREQ = 2**N;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_d;
  logic [N-1:0] ptr;
  logic [N-1:0] ptr_d;
  logic [N-1:0] index_d;
  logic         valid_d;
  logic         hs;
  logic         any_req;
  logic         lock_hold;
  logic [N-1:0] next_base;

  // First requester at or after base, wrapping modulo 2**N.
  function automatic logic [N-1:0] sel(input logic [N-1:0] base, input logic [NREQ-1:0] r);
    logic [N-1:0] idx;
    logic         found;
    sel   = base;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = base + N'(i);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign any_req   = |req;
  assign hs        = grant_valid && grant_ready;
  assign next_base = grant_index + N'(1);

`ifdef RR_GRANT_LOCK_EN
  assign lock_hold = req[grant_index];
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      grant_index <= index_d;
      grant_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (hs && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A presented grant is held untouched until the handshake.
  always_comb begin
    ptr_d   = ptr;
    index_d = grant_index;
    valid_d = grant_valid;
    case (state)
      IDLE: begin
        if (any_req) begin
          index_d = sel(ptr, req);
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (hs && !lock_hold) begin
          ptr_d = next_base;
          if (any_req) index_d = sel(next_base, req);
          else         valid_d = 1'b0;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

endmodule

// File: doc/rr_grant_encoder.md
# rr_grant_encoder

- Round-robin arbiter over `2**N` request lines.
- Issues one registered binary grant index per transaction on a valid/ready handshake.
- Sits directly upstream of the `N`-bit binary-to-one-hot decoder: `grant_index` drives the decoder's binary input, and the decoder's one-hot output serves as the grant vector back to requesters.
- Keeps the index stable until accepted, so the decoded one-hot grant never glitches mid-transaction.

## Interface
- `N`, default 4: index width; number of requesters is `2**N`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  `2**N`  request lines; bit `i` = requester `i` wants a grant.
- `grant_valid`  out  1  a grant index is presented.
- `grant_ready`  in  1  consumer accepts the presented grant.
- `grant_index`  out  `N`  binary index of the granted requester.

## Operation
- Internal state:
  - FSM states IDLE and GRANT.
  - `N`-bit round-robin pointer `ptr`.
  - Registered `grant_index` and `grant_valid`.
- Selection function `sel(ptr, req)`:
  - Returns the first set bit of `req` scanning indices `ptr, ptr+1, …, 2**N-1, 0, …, ptr-1`.
  - Index arithmetic is modulo `2**N` (natural `N`-bit wrap).
- IDLE:
  - If `|req`: load `grant_index <= sel(ptr, req)`, set `grant_valid <= 1`, go to GRANT.
  - Else stay; `grant_valid` stays 0.
- GRANT:
  - Handshake occurs when `grant_valid && grant_ready`.
  - Without handshake: hold `grant_index` and `grant_valid` unchanged, even if `req[grant_index]` drops. A presented grant is never withdrawn or changed.
  - On handshake, update `ptr <= grant_index + 1` (wraps `2**N-1` -> 0).
  - On handshake with `|req`: load `grant_index <= sel(grant_index + 1, req)` in the same edge and stay in GRANT (back-to-back). This uses the current-cycle `req`, so the just-served requester has lowest priority and is re-granted only if it is the sole requester.
  - On handshake with `req == 0`: `grant_valid <= 0`, go to IDLE.
- `ptr` changes only on handshake.
- `grant_index` changes only on entry to GRANT or on handshake.
- Reset (any state, any cycle): at the next edge with `rst_n == 0`:
  - state IDLE, `ptr = 0`, `grant_index = 0`, `grant_valid = 0`.
  - A pending unaccepted grant is dropped.
  - `req` is ignored while `rst_n == 0`.

## Timing
- Reset values: `grant_valid = 0`, `grant_index = 0`.
- Latency: `req` sampled at edge k in IDLE -> `grant_valid = 1` with the index valid after edge k (visible in cycle k+1).
- No combinational path from `req` or `grant_ready` to any output.
- Throughput: one grant per cycle while `grant_ready` is held 1 and requests are present.
- From IDLE, there is one cycle of request-to-grant latency and no bubble.
- `grant_ready` may be asserted before `grant_valid`; it is ignored while `grant_valid = 0`.

## Configuration
- Macro `RR_GRANT_LOCK_EN`.
- Defined (burst lock):
  - On handshake, if `req[grant_index]` is still 1, re-grant the same index and leave `ptr` unchanged.
  - When that request is 0, advance as in round-robin mode.
  - A requester keeps ownership for consecutive transactions while it keeps requesting.
- Undefined: pure round-robin as described in Operation; no lock logic is synthesised.

## Test plan
Scenarios use `N = 2`, lock undefined unless stated.
- Reset: hold `rst_n = 0` 2 cycles with `req = 4'b1111` -> `grant_valid = 0`, `grant_index = 0` throughout. Release -> next cycle `grant_valid = 1`, `grant_index = 0`.
- Rotation: `req = 4'b1111`, `grant_ready = 1` constantly -> indices 0, 1, 2, 3, 0, 1 on consecutive cycles (wrap from 3 to 0 checked).
- Backpressure: `req = 4'b0100`, `grant_ready = 0` for 5 cycles, and `req` drops to 0 in cycle 2 -> `grant_index = 2`, `grant_valid = 1` held all 5 cycles. Raise `grant_ready` -> handshake, then `grant_valid = 0` and state IDLE.
- Fairness skip: `ptr = 3` after a grant of index 2, then `req = 4'b0101` -> next grants 0 then 2. Index 1 (not requesting) is never issued.
- Mid-transaction reset: `grant_valid = 1` with index 3 pending, `rst_n = 0` one cycle -> next cycle `grant_valid = 0`, `grant_index = 0`. After release with `req = 4'b1000` -> index 3 granted with `ptr` restarted at 0.
- Lock (`RR_GRANT_LOCK_EN` defined): `req = 4'b0011` held, `grant_ready = 1` -> index 0 repeated. Drop `req[0]` -> index 1 next, then repeated while `req[1]` is held.
